seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 op  input  5  operation code, alu_op_t from alu_pkg.
REQ-007 a  input  XLEN  operand A.
REQ-008 b  input  XLEN  operand B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero  output  1  registered flag, high when result equals 0.

Function
REQ-013 The block SHALL accept a request on a rising edge where in_valid and in_ready are both high; a, b and op SHALL be captured at that edge.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-015 Base ops 0x00-0x0D SHALL be: add, sub, sll, slt, sltu, xor, srl, sra, or, and, sge, seq, sne, sgeu; IDLE->DONE on accept, out_valid high 1 cycle after the accept edge.
REQ-016 Shift amount SHALL be b[$clog2(XLEN)-1:0]; sra SHALL replicate a[XLEN-1].
REQ-017 Compare ops SHALL return 1 or 0 zero-extended to XLEN.
REQ-018 M-ops 0x10-0x17 SHALL be mul, mulh, mulhsu, mulhu, div, divu, rem, remu with RISC-V M semantics at XLEN; IDLE->BUSY on accept.
REQ-019 BUSY SHALL last exactly XLEN cycles (radix-2 iteration, counter XLEN-1 down to 0), then ->DONE; out_valid high XLEN+1 cycles after the accept edge.
REQ-020 Divide by zero: div/divu quotient SHALL be all ones, rem/remu SHALL return a.
REQ-021 Signed overflow (a = most-negative, b = -1): div SHALL return a, rem SHALL return 0.
REQ-022 Divide-by-zero and overflow SHALL still take the full XLEN BUSY cycles.
REQ-023 In DONE, result, zero and out_valid SHALL hold stable until out_ready is high; DONE->IDLE on that edge.
REQ-024 Undefined op codes SHALL be treated as base ops with result 0, zero=1, latency 1.
REQ-025 Inputs SHALL be ignored outside IDLE; in_valid without in_ready SHALL have no effect.

Reset
REQ-026 Reset SHALL force IDLE, out_valid=0, result=0, zero=1, iteration counter=0.
REQ-027 Reset in BUSY or DONE SHALL discard the operation; no out_valid SHALL follow; in_ready SHALL be high the cycle after reset deasserts.
REQ-028 Reset SHALL take priority over an accept on the same edge.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined: M-ops per REQ-018..022 and sub-module instantiated.
REQ-030 Macro undefined: M-op codes SHALL behave as undefined ops (REQ-024), BUSY SHALL be unreachable, no multiply/divide logic SHALL be present.

Structure
REQ-031 Package alu_pkg SHALL hold alu_op_t enum (5-bit, all codes above) and the state enum.
REQ-032 Iterative multiply/divide datapath SHALL live in sub-module seq_alu_muldiv (start, done, operands, signedness, result), instantiated only under SEQ_ALU_MULDIV_EN.

Verification
REQ-033 XLEN=32, add a=0xFFFFFFFF b=1 -> result 0, zero=1, out_valid 1 cycle after accept.
REQ-034 sra a=0x80000000 b=0x24 -> result 0xF8000000 (shift 4); sltu a=1 b=0xFFFFFFFF -> 1.
REQ-035 MULDIV_EN, mulh a=0x80000000 b=0x80000000 -> 0x40000000, out_valid exactly 33 cycles after accept.
REQ-036 div a=7 b=0 -> 0xFFFFFFFF; rem a=0x80000000 b=0xFFFFFFFF -> 0; divu a=100 b=7 -> 14.
REQ-037 out_ready held low 5 cycles in DONE -> result stable, in_ready low; request presented meanwhile not accepted.
REQ-038 Reset asserted at BUSY cycle 10 of a div -> no out_valid, next add a=2 b=3 -> 5 with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for seq_alu: operation codes, FSM states and op classification.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00, OP_SUB    = 5'h01, OP_SLL    = 5'h02, OP_SLT    = 5'h03,
    OP_SLTU   = 5'h04, OP_XOR    = 5'h05, OP_SRL    = 5'h06, OP_SRA    = 5'h07,
    OP_OR     = 5'h08, OP_AND    = 5'h09, OP_SGE    = 5'h0A, OP_SEQ    = 5'h0B,
    OP_SNE    = 5'h0C, OP_SGEU   = 5'h0D,
    OP_MUL    = 5'h10, OP_MULH   = 5'h11, OP_MULHSU = 5'h12, OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14, OP_DIVU   = 5'h15, OP_REM    = 5'h16, OP_REMU   = 5'h17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // M-extension codes occupy 0x10..0x17.
  function automatic logic is_mop(input logic [4:0] code);
    return code[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Radix-2 iterative multiply/divide: one bit per cycle for exactly XLEN cycles,
// operating on magnitudes and fixing signs on the final cycle.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_div,
  input  logic            hi_sel,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic          busy;
  logic [CW-1:0] cnt;

  logic [XLEN-1:0] hi_r, lo_r, d_r, a_r;
  logic            div_r, hi_sel_r, neg_q_r, neg_r_r, dz_r;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [XLEN:0]     sum, r_sh, diff;
  logic [XLEN-1:0]   hi_nxt, lo_nxt, quo, rem;
  logic [2*XLEN-1:0] prod, prod_s;

  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(XLEN - 1);
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

  // Multiply keeps the multiplicand in d_r and the multiplier in lo_r;
  // divide keeps the divisor in d_r and the dividend in lo_r.
  always_ff @(posedge clk) begin
    if (start) begin
      hi_r     <= '0;
      lo_r     <= is_div ? mag_a : mag_b;
      d_r      <= is_div ? mag_b : mag_a;
      a_r      <= a;
      div_r    <= is_div;
      hi_sel_r <= hi_sel;
      neg_q_r  <= a_neg ^ b_neg;
      neg_r_r  <= a_neg;
      dz_r     <= (b == '0);
    end else if (busy) begin
      hi_r <= hi_nxt;
      lo_r <= lo_nxt;
    end
  end

  always_comb begin
    sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, d_r} : '0);
    r_sh = {hi_r, lo_r[XLEN-1]};
    diff = r_sh - {1'b0, d_r};
    if (div_r) begin
      hi_nxt = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_nxt = {lo_r[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo_r[XLEN-1:1]};
    end
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_q_r ? -prod : prod;
    quo    = neg_q_r ? -lo_nxt : lo_nxt;
    rem    = neg_r_r ? -hi_nxt : hi_nxt;
    if (div_r) begin
      if (hi_sel_r) result = dz_r ? a_r : rem;
      else          result = dz_r ? '1 : quo;
    end else begin
      result = hi_sel_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; single-cycle base ops and, when
// SEQ_ALU_MULDIV_EN is defined, iterative M-extension multiply/divide.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int SHW = $clog2(XLEN);

  state_t          state, state_nxt;
  logic            accept, mop_sel, md_done;
  logic [XLEN-1:0] md_result, alu_val, res_val;
  logic            res_load;

  function automatic logic [XLEN-1:0] flag(input logic c);
    logic [XLEN-1:0] r;
    r    = '0;
    r[0] = c;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] base_alu(input logic [4:0] code,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (code)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLL:  return x << sh;
      OP_SLT:  return flag($signed(x) < $signed(y));
      OP_SLTU: return flag(x < y);
      OP_XOR:  return x ^ y;
      OP_SRL:  return x >> sh;
      OP_SRA:  return XLEN'($signed(x) >>> sh);
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      OP_SGE:  return flag($signed(x) >= $signed(y));
      OP_SEQ:  return flag(x == y);
      OP_SNE:  return flag(x != y);
      OP_SGEU: return flag(x >= y);
      default: return '0;
    endcase
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign alu_val   = base_alu(op, a, b);

`ifdef SEQ_ALU_MULDIV_EN
  assign mop_sel = is_mop(op);

  seq_alu_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && mop_sel),
    .is_div   (op[2]),
    .hi_sel   (op[2] ? op[1] : (op[1:0] != 2'b00)),
    .a_signed (op[2] ? ~op[0] : (op[1:0] != 2'b11)),
    .b_signed (op[2] ? ~op[0] : ~op[1]),
    .a        (a),
    .b        (b),
    .done     (md_done),
    .result   (md_result)
  );
`else
  assign mop_sel   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    res_val   = alu_val;
    case (state)
      IDLE: if (in_valid) begin
        state_nxt = mop_sel ? BUSY : DONE;
        res_load  = !mop_sel;
      end
      BUSY: if (md_done) begin
        state_nxt = DONE;
        res_load  = 1'b1;
        res_val   = md_result;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (res_load) begin
        result <= res_val;
        zero   <= (res_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (XLEN=32); M-op vectors apply when SEQ_ALU_MULDIV_EN is defined.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic        seen;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_wait(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int l);
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int l;
    issue_wait(o, x, y, l);
    check({tag, "_result"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    check({tag, "_latency"}, 32'(l), 32'(exp_lat));
    consume();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    op_chk("add_wrap", 5'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    op_chk("sub",      5'h01, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    op_chk("sll",      5'h02, 32'd1, 32'h23, 32'd8, 1);
    op_chk("slt",      5'h03, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    op_chk("sltu",     5'h04, 32'd1, 32'hFFFF_FFFF, 32'd1, 1);
    op_chk("xor",      5'h05, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
    op_chk("srl",      5'h06, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    op_chk("sra",      5'h07, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    op_chk("or",       5'h08, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    op_chk("and",      5'h09, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    op_chk("sge",      5'h0A, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    op_chk("seq",      5'h0B, 32'd5, 32'd5, 32'd1, 1);
    op_chk("sne",      5'h0C, 32'd5, 32'd5, 32'd0, 1);
    op_chk("sgeu",     5'h0D, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    op_chk("undef_0e", 5'h0E, 32'd5, 32'd3, 32'd0, 1);
    op_chk("undef_1f", 5'h1F, 32'd5, 32'd3, 32'd0, 1);

`ifdef SEQ_ALU_MULDIV_EN
    op_chk("mulh_minmin", 5'h11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    op_chk("mul_neg",     5'h10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    op_chk("mulhu",       5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    op_chk("mulhsu",      5'h12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    op_chk("div_by0",     5'h14, 32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    op_chk("rem_ovf",     5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    op_chk("div_ovf",     5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    op_chk("divu",        5'h15, 32'd100, 32'd7, 32'd14, 33);
    op_chk("rem_neg",     5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    op_chk("remu_by0",    5'h17, 32'd9, 32'd0, 32'd9, 33);
    op_chk("divu_by0",    5'h15, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);

    // Reset ten cycles into a divide: the operation is dropped.
    in_valid = 1'b1; op = 5'h14; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("busy_rst_out_valid", 32'(out_valid), 32'd0);
    check("busy_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("busy_rst_no_result", 32'(seen), 32'd0);
    op_chk("add_after_rst", 5'h00, 32'd2, 32'd3, 32'd5, 1);
`else
    op_chk("mop_as_undef_mul", 5'h10, 32'd7, 32'd3, 32'd0, 1);
    op_chk("mop_as_undef_div", 5'h14, 32'd100, 32'd7, 32'd0, 1);
`endif

    // Back-pressure in DONE: result held, competing request ignored.
    issue_wait(5'h00, 32'd2, 32'd3, lat);
    check("bp_first", result, 32'd5);
    in_valid = 1'b1; op = 5'h00; a = 32'd100; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result_hold", result, 32'd5);
      check("bp_out_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    check("bp_released_out_valid", 32'(out_valid), 32'd0);
    check("bp_released_in_ready", 32'(in_ready), 32'd1);
    check("bp_released_result", result, 32'd5);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_request_not_taken", 32'(seen), 32'd0);

    // Reset while DONE clears the result registers.
    issue_wait(5'h00, 32'd9, 32'd1, lat);
    check("done_before_rst", result, 32'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    check("done_rst_result", result, 32'd0);
    check("done_rst_zero", 32'(zero), 32'd1);

    // Reset wins over a simultaneous accept.
    reset = 1'b1; in_valid = 1'b1; op = 5'h00; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check("rst_prio_out_valid", 32'(out_valid), 32'd0);
    check("rst_prio_in_ready", 32'(in_ready), 32'd1);
    check("rst_prio_result", result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
